pe_operand_join: RTL
====================

# pe_operand_join

Operand-collection stage placed directly upstream of a PE's functional unit. It buffers two independent operand streams, A and B, in small FIFOs and joins them into one operand pair with a single valid. During accumulation it substitutes a registered copy of the functional-unit result for operand A. It drives the functional unit's `a_i`/`b_i`/`ops_valid_i` and observes its `res_o`/`acc_loopback_o`.

## Interface
- `N_BITS`, 32, operand/result width
- `FIFO_DEPTH`, 2, entries per operand FIFO; power of two, ≥2
- `clk_i` in 1, clock
- `rst_n_i` in 1, reset; one clock, asynchronous, active-low
- `flush_i` in 1, synchronous clear of both FIFOs and the accumulator copy
- `ops_mask_i` in 2, bit0 = instruction uses A, bit1 = instruction uses B; static while operands are in flight
- `a_data_i` in N_BITS, A stream data
- `a_valid_i` in 1, A stream valid
- `a_ready_o` out 1, A stream ready
- `b_data_i` in N_BITS, B stream data
- `b_valid_i` in 1, B stream valid
- `b_ready_o` out 1, B stream ready
- `acc_loopback_i` in 1, from FU `acc_loopback_o`; replaces A with the accumulator copy
- `fu_res_i` in N_BITS, FU `res_o` (combinational, same cycle as fire)
- `pea_ready_i` in 1, array-level downstream ready
- `a_o` out N_BITS, operand A to FU
- `b_o` out N_BITS, operand B to FU
- `ops_valid_o` out 1, operand pair valid
- `a_count_o`, `b_count_o` out $clog2(FIFO_DEPTH)+1, FIFO occupancy

## Operation
- FIFOs
  - One circular FIFO per stream: storage, rd/wr pointers, count.
  - Push on `x_valid_i && x_ready_o`.
  - `x_ready_o = (count != FIFO_DEPTH)`, decoded from the registered count only. A full FIFO is not ready even in a cycle where it pops (no pass-through).
  - Pointers wrap modulo FIFO_DEPTH.
- Required operands
  - `need_a = ops_mask_i[0] && !acc_loopback_i`
  - `need_b = ops_mask_i[1]`
- Valid and fire
  - `ops_valid_o = (need_a || need_b || acc_loopback_i) && (!need_a || a_count!=0) && (!need_b || b_count!=0)`
  - `ops_mask_i == 2'b00` with no loopback gives `ops_valid_o = 0` (NOP consumes nothing).
  - `fire = ops_valid_o && pea_ready_i`. The FU always reports ready, so no FU ready is needed.
  - On fire, pop each FIFO whose `need_x` is 1. Unneeded FIFOs keep their contents.
- Operand muxing
  - `a_o`: `acc_q` if `acc_loopback_i`; else A FIFO head if `need_a`; else 0.
  - `b_o`: B FIFO head if `need_b`; else 0.
- Accumulator copy
  - `acc_q <= fu_res_i` on every fire, so the next loopback operand is the last FU result.
  - This register breaks the combinational res→a path.
- Flush
  - Zeroes pointers, counts and `acc_q`.
  - Flush wins over a simultaneous push or pop: the pushed beat is dropped and the upstream sees the handshake complete.
- Arithmetic
  - No arithmetic on data.
  - Counts are unsigned, with no overflow or underflow possible because of the ready and valid gating.

## Timing
- Reset values
  - `a_ready_o = b_ready_o = 1`, `ops_valid_o = 0`, `a_o = b_o = 0`.
  - Counts 0, `acc_q = 0`, FIFO storage 0.
- Latency
  - A beat pushed in cycle t appears at the FIFO head, and can raise `ops_valid_o`, in cycle t+1. There is no empty-FIFO bypass.
- Throughput
  - One fire per cycle while both needed FIFOs are non-empty.
  - Sustained full rate per stream requires FIFO_DEPTH ≥ 2.
- Simultaneous push and pop on a non-full FIFO: count unchanged and both pointers advance.
- Stall: with `pea_ready_i = 0`, `ops_valid_o`, `a_o` and `b_o` hold stable (the head is not popped). Upstream fills its FIFO and then sees ready = 0.
- `acc_loopback_i` changes at most once per fire (it is an FU register). Valid recomputes combinationally in the same cycle.
- An asynchronous reset mid-operation discards all buffered beats and `acc_q`. Outputs take their reset values immediately.

## Test plan
- **Reset and join.** Reset, then mask=11. Push A=5 in cycle 1 and B=7 in cycle 3, with pea_ready=1.
  - `ops_valid_o` stays 0 until cycle 4, then is 1 for exactly one cycle with a_o=5, b_o=7.
  - Both counts return to 0.
- **Full and backpressure.** DEPTH=2, pea_ready=0, push A=1,2,3 continuously.
  - `a_ready_o` drops after 2 pushes and `a_count_o` = 2.
  - Raise pea_ready with B supplied: pairs leave in order 1 then 2, and 3 is accepted only after a slot frees.
- **Accumulation loopback.** mask=11, B stream 1,2,3, A=10, FU returns a+b. Assert acc_loopback after the first fire.
  - Fires: a_o = 10, 11, 13.
  - Only B pops after the first fire; the A FIFO is left untouched.
- **Single-operand.** mask=01, A stream −4 (0xFFFFFFFC), B FIFO holding 9.
  - One fire with a_o=0xFFFFFFFC and b_o=0.
  - B count stays 1.
- **Flush collision.** A FIFO holds 1 entry. Assert flush_i in the same cycle as a push of 0x55 and a pop.
  - Next cycle: counts are 0, acc_q is 0, ops_valid_o is 0.
  - 0x55 never appears.
- **Mid-stream reset.** FIFOs are partly full. Pulse rst_n_i low mid-cycle.
  - All outputs are at their reset values asynchronously.
  - The first fire after reset carries only beats pushed after reset.

Source files
------------

// File: rtl/pe_operand_join.sv
// Buffers A/B operand streams in FIFOs and joins them into one FU operand pair; on loopback a registered FU result replaces A.
// Latency: push-to-head 1 cycle, no bypass; backpressure: x_ready_o low only while that FIFO is full (registered count).
module pe_operand_join #(
  parameter int N_BITS     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [1:0]                    ops_mask_i,
  input  logic [N_BITS-1:0]             a_data_i,
  input  logic                          a_valid_i,
  output logic                          a_ready_o,
  input  logic [N_BITS-1:0]             b_data_i,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  input  logic                          acc_loopback_i,
  input  logic [N_BITS-1:0]             fu_res_i,
  input  logic                          pea_ready_i,
  output logic [N_BITS-1:0]             a_o,
  output logic [N_BITS-1:0]             b_o,
  output logic                          ops_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   a_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   b_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic              need_a;
  logic              need_b;
  logic              fire;
  logic [1:0]        in_vld;
  logic [1:0]        pop_req;
  logic [1:0]        fifo_rdy;
  logic [N_BITS-1:0] in_dat [2];
  logic [N_BITS-1:0] head   [2];
  logic [CW-1:0]     cnt    [2];
  logic [N_BITS-1:0] acc_q;
  logic [N_BITS-1:0] acc_d;

  assign need_a = ops_mask_i[0] && !acc_loopback_i;
  assign need_b = ops_mask_i[1];

  assign ops_valid_o = (need_a || need_b || acc_loopback_i)
                    && (!need_a || (cnt[0] != '0))
                    && (!need_b || (cnt[1] != '0));
  assign fire = ops_valid_o && pea_ready_i;

  assign in_vld    = {b_valid_i, a_valid_i};
  assign in_dat[0] = a_data_i;
  assign in_dat[1] = b_data_i;
  assign pop_req   = {fire && need_b, fire && need_a};

  assign a_ready_o = fifo_rdy[0];
  assign b_ready_o = fifo_rdy[1];
  assign a_count_o = cnt[0];
  assign b_count_o = cnt[1];

  assign a_o = acc_loopback_i ? acc_q : (need_a ? head[0] : '0);
  assign b_o = need_b ? head[1] : '0;

  // Index 0 is the A stream, index 1 the B stream.
  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [N_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     rd_ptr_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              do_push;
    logic              do_pop;

    assign fifo_rdy[s] = (cnt_q != CW'(FIFO_DEPTH));
    assign do_push     = in_vld[s] && fifo_rdy[s] && !flush_i;
    assign do_pop      = pop_req[s] && !flush_i;
    assign head[s]     = mem_q[rd_ptr_q];
    assign cnt[s]      = cnt_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        if (do_push) mem_q[wr_ptr_q] <= in_dat[s];
      end
    end
  end

  // Registered FU result keeps the res->a path out of a combinational loop.
  always_comb begin
    acc_d = acc_q;
    if (flush_i)   acc_d = '0;
    else if (fire) acc_d = fu_res_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule
